ci_trigger_averager: RTL

Parametrised successor to the four-channel custom-instrument top. It takes NUM_CH signed input channels and runs a trigger-gated boxcar averager on each one. Once per armed trigger it accumulates 2^N samples per channel, then publishes the averages on the outputs and holds them. It sits directly behind the instrument's ADC inputs and is configured and monitored through the 16-word control/status register arrays.

---
 rtl/ci_avg_pkg.sv | 32 +++
 rtl/ci_avg_channel.sv | 49 ++++
 rtl/ci_trigger_averager.sv | 126 ++++++++++++
 3 files changed

// File: rtl/ci_avg_pkg.sv
// ci_avg_pkg: shared state encoding, control/status word indices and the averaging-count clamp
// for ci_trigger_averager.
package ci_avg_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_HOLDOFF = 3'd2,
        S_ACCUM   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam int CTL_CFG   = 0;
    localparam int CTL_LOG2  = 1;
    localparam int CTL_HOLD  = 2;
    localparam int CTL_LEVEL = 3;

    localparam int CFG_EN    = 0;
    localparam int CFG_ARM   = 1;
    localparam int CFG_SRC   = 2;
    localparam int CFG_REARM = 3;

    localparam int ST_STATE = 0;
    localparam int ST_DONE  = 1;
    localparam int ST_MISS  = 2;
    localparam int ST_SYNC  = 3;

    function automatic logic [3:0] clamp_log2(input logic [3:0] n, input logic [3:0] max_n);
        return (n > max_n) ? max_n : n;
    endfunction

endpackage

// File: rtl/ci_avg_channel.sv
// ci_avg_channel: one channel's boxcar accumulator and divide-by-2^N output stage.
// CI_AVG_ROUND_EN selects round-half-up instead of a truncating arithmetic shift.
module ci_avg_channel
    import ci_avg_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int MAX_LOG2 = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     acc_en,
    input  logic                     done,
    input  logic [3:0]               n,
    input  logic signed [DATA_W-1:0] sample,
    output logic signed [DATA_W-1:0] avg
);
    localparam int AW = DATA_W + MAX_LOG2;

    logic signed [AW-1:0]     acc_q, acc_d;
    logic signed [DATA_W-1:0] avg_q, avg_d;
`ifdef CI_AVG_ROUND_EN
    logic signed [AW:0]       bias, sum;
`endif

    // The accumulator only holds a value while accumulating; every other state clears it.
    always_comb begin
        acc_d = acc_en ? acc_q + AW'(sample) : '0;
`ifdef CI_AVG_ROUND_EN
        bias  = (n == 4'd0) ? '0 : (AW+1)'(1) << (n - 4'd1);
        sum   = (AW+1)'(acc_q) + bias;
        avg_d = done ? DATA_W'(sum >>> n) : avg_q;
`else
        avg_d = done ? DATA_W'(acc_q >>> n) : avg_q;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            avg_q <= '0;
        end else begin
            acc_q <= acc_d;
            avg_q <= avg_d;
        end
    end

    assign avg = avg_q;

endmodule

// File: rtl/ci_trigger_averager.sv
// ci_trigger_averager: trigger-gated boxcar averager over NUM_CH signed channels with
// control/status register arrays. Define CI_AVG_ROUND_EN for rounded averages.
module ci_trigger_averager
    import ci_avg_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 16,
    parameter int MAX_LOG2  = 12,
    parameter int HOLDOFF_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [31:0]                sync,
    input  logic [NUM_CH*DATA_W-1:0]   inputs,
    input  logic                       exttrig,
    output logic [NUM_CH*DATA_W-1:0]   outputs,
    output logic                       avg_valid,
    input  logic [31:0]                control [16],
    output logic [31:0]                status  [16]
);
    state_t                   state_q, state_d;
    logic                     arm_q, ext_q, valid_q, valid_d;
    logic signed [DATA_W-1:0] ch0_q, ch0, thr;
    logic [3:0]               n_q, n_d;
    logic [HOLDOFF_W-1:0]     hold_q, hold_d, hcnt_q, hcnt_d;
    logic [MAX_LOG2:0]        scnt_q, scnt_d;
    logic [31:0]              done_cnt_q, done_cnt_d, miss_q, miss_d, sync_q, sync_d;
    logic                     en, arm_edge, trig, hold_go, accum_last, unused;

    always_comb begin
        ch0        = inputs[DATA_W-1:0];
        thr        = control[CTL_LEVEL][DATA_W-1:0];
        en         = control[CTL_CFG][CFG_EN];
        arm_edge   = control[CTL_CFG][CFG_ARM] & ~arm_q;
        trig       = control[CTL_CFG][CFG_SRC] ? (ch0_q < thr && ch0 >= thr) : (exttrig & ~ext_q);
        hold_go    = hold_q == '0 || hcnt_q == hold_q - HOLDOFF_W'(1);
        accum_last = scnt_q == ((MAX_LOG2+1)'(1) << n_q) - (MAX_LOG2+1)'(1);
        hcnt_d     = state_q == S_HOLDOFF ? hcnt_q + HOLDOFF_W'(1) : '0;
        scnt_d     = state_q == S_ACCUM ? scnt_q + (MAX_LOG2+1)'(1) : '0;
        valid_d    = en && state_q == S_DONE;
        done_cnt_d = done_cnt_q + 32'(valid_d);
        miss_d     = ((state_q == S_HOLDOFF || state_q == S_ACCUM) && trig && miss_q != '1) ? miss_q + 32'd1 : miss_q;
        state_d    = state_q;
        sync_d     = sync_q;
        n_d        = n_q;
        hold_d     = hold_q;
        case (state_q)
            S_IDLE:    if (arm_edge) state_d = S_ARMED;
            S_ARMED:   if (trig) begin
                state_d = S_HOLDOFF;
                sync_d  = sync;
            end
            S_HOLDOFF: if (hold_go) state_d = S_ACCUM;
            S_ACCUM:   if (accum_last) state_d = S_DONE;
            S_DONE:    state_d = control[CTL_CFG][CFG_REARM] ? S_ARMED : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        if (!en) begin
            state_d = S_IDLE;
            sync_d  = sync_q;
        end
        // Capture parameters are frozen on every entry to ARMED, including auto-rearm.
        if (state_d == S_ARMED && state_q != S_ARMED) begin
            n_d    = clamp_log2(control[CTL_LOG2][3:0], 4'(MAX_LOG2));
            hold_d = control[CTL_HOLD][HOLDOFF_W-1:0];
        end
    end

    always_comb begin
        unused = 1'b0;
        for (int i = 0; i < 16; i++) unused = unused ^ (^control[i]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            arm_q      <= 1'b0;
            ext_q      <= 1'b0;
            ch0_q      <= '0;
            valid_q    <= 1'b0;
            n_q        <= '0;
            hold_q     <= '0;
            hcnt_q     <= '0;
            scnt_q     <= '0;
            done_cnt_q <= '0;
            miss_q     <= '0;
            sync_q     <= '0;
        end else begin
            state_q    <= state_d;
            arm_q      <= control[CTL_CFG][CFG_ARM];
            ext_q      <= exttrig;
            ch0_q      <= ch0;
            valid_q    <= valid_d;
            n_q        <= n_d;
            hold_q     <= hold_d;
            hcnt_q     <= hcnt_d;
            scnt_q     <= scnt_d;
            done_cnt_q <= done_cnt_d;
            miss_q     <= miss_d;
            sync_q     <= sync_d;
        end
    end

    always_comb begin
        for (int i = 0; i < 16; i++) status[i] = '0;
        status[ST_STATE] = 32'(state_q);
        status[ST_DONE]  = done_cnt_q;
        status[ST_MISS]  = miss_q;
        status[ST_SYNC]  = sync_q;
    end

    assign avg_valid = valid_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        ci_avg_channel #(.DATA_W(DATA_W), .MAX_LOG2(MAX_LOG2)) u_ch (
            .clk    (clk),
            .reset  (reset),
            .acc_en (state_q == S_ACCUM),
            .done   (valid_d),
            .n      (n_q),
            .sample (inputs[k*DATA_W +: DATA_W]),
            .avg    (outputs[k*DATA_W +: DATA_W])
        );
    end

endmodule
